// File: rtl/alu_iter.sv
// ============================================================================
//  Module   : alu_iter
//  Brief    : Multi-cycle ALU with iterative unsigned multiply/divide and
//             valid/ready handshakes on request and result.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_iter #(
  parameter int WIDTH  = 32,
  parameter int MUL_EN = 1,
  parameter int DIV_EN = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_ctr,
  input  logic [WIDTH-1:0] inp_a,
  input  logic [WIDTH-1:0] inp_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_hi,
  output logic             zero,
  output logic             v_flg,
  output logic             c_out,
  output logic             div_by_zero
);

  localparam int c_sh_w = $clog2(WIDTH);
  localparam logic [c_sh_w-1:0] c_last = c_sh_w'(WIDTH - 1);

  localparam logic [3:0] c_op_add  = 4'b0001;
  localparam logic [3:0] c_op_sub  = 4'b0010;
  localparam logic [3:0] c_op_sll  = 4'b0011;
  localparam logic [3:0] c_op_srl  = 4'b0100;
  localparam logic [3:0] c_op_sra  = 4'b0101;
  localparam logic [3:0] c_op_and  = 4'b0110;
  localparam logic [3:0] c_op_or   = 4'b0111;
  localparam logic [3:0] c_op_xor  = 4'b1000;
  localparam logic [3:0] c_op_nor  = 4'b1010;
  localparam logic [3:0] c_op_slt  = 4'b1011;
  localparam logic [3:0] c_op_mulu = 4'b1100;
  localparam logic [3:0] c_op_divu = 4'b1101;
  localparam logic [3:0] c_op_eq   = 4'b1110;
  localparam logic [3:0] c_op_sltu = 4'b1111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t              r_state;
  logic [c_sh_w-1:0]   r_cnt;
  logic [WIDTH-1:0]    r_op;   // multiplicand or divisor
  logic [WIDTH-1:0]    r_hi;   // partial product high half / remainder
  logic [WIDTH-1:0]    r_lo;   // multiplier shifting out / dividend->quotient

  logic [c_sh_w-1:0]   w_sh;
  logic [WIDTH:0]      w_add;
  logic [WIDTH:0]      w_sub;
  logic [WIDTH-1:0]    w_res;
  logic [WIDTH-1:0]    w_res_hi;
  logic                w_v;
  logic                w_c;
  logic                w_dbz;
  logic                w_start_mul;
  logic                w_start_div;

  logic [WIDTH:0]      w_mul_sum;
  logic [WIDTH-1:0]    w_mul_hi;
  logic [WIDTH-1:0]    w_mul_lo;

  logic [WIDTH-1:0]    w_div_sh_lo;
  logic                w_div_ge;
  logic [WIDTH-1:0]    w_div_diff;
  logic [WIDTH-1:0]    w_div_rem;
  logic [WIDTH-1:0]    w_div_q;

  assign w_sh  = inp_a[c_sh_w-1:0];
  assign w_add = {1'b0, inp_a} + {1'b0, inp_b};
  assign w_sub = {1'b0, inp_a} + {1'b0, ~inp_b} + {{WIDTH{1'b0}}, 1'b1};

  assign w_start_mul = (alu_ctr == c_op_mulu) && (MUL_EN != 0);
  assign w_start_div = (alu_ctr == c_op_divu) && (DIV_EN != 0) && (inp_b != '0);

  always_comb begin
    w_res    = '0;
    w_res_hi = '0;
    w_v      = 1'b0;
    w_c      = 1'b0;
    w_dbz    = 1'b0;
    case (alu_ctr)
      c_op_add: begin
        w_res = w_add[WIDTH-1:0];
        w_c   = w_add[WIDTH];
        w_v   = (inp_a[WIDTH-1] == inp_b[WIDTH-1]) && (w_add[WIDTH-1] != inp_a[WIDTH-1]);
      end
      c_op_sub: begin
        w_res = w_sub[WIDTH-1:0];
        w_c   = w_sub[WIDTH];
        w_v   = (inp_a[WIDTH-1] != inp_b[WIDTH-1]) && (w_sub[WIDTH-1] != inp_a[WIDTH-1]);
      end
      c_op_sll:  w_res = inp_b << w_sh;
      c_op_srl:  w_res = inp_b >> w_sh;
      c_op_sra:  w_res = $signed(inp_b) >>> w_sh;
      c_op_and:  w_res = inp_a & inp_b;
      c_op_or:   w_res = inp_a | inp_b;
      c_op_xor:  w_res = inp_a ^ inp_b;
      c_op_nor:  w_res = ~(inp_a | inp_b);
      c_op_slt:  w_res = {{(WIDTH-1){1'b0}}, ($signed(inp_a) < $signed(inp_b))};
      c_op_eq:   w_res = {{(WIDTH-1){1'b0}}, (inp_a == inp_b)};
      c_op_sltu: w_res = {{(WIDTH-1){1'b0}}, (inp_a < inp_b)};
      c_op_divu: begin
        // Only the divide-by-zero case reaches the single-cycle path.
        if (DIV_EN != 0) begin
          w_res    = '1;
          w_res_hi = inp_a;
          w_dbz    = 1'b1;
        end
      end
      default: w_res = '0;
    endcase
  end

  // Shift-add step: conditionally add multiplicand, then shift right.
  assign w_mul_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_op} : {(WIDTH+1){1'b0}});
  assign w_mul_hi  = w_mul_sum[WIDTH:1];
  assign w_mul_lo  = {w_mul_sum[0], r_lo[WIDTH-1:1]};

  // Restoring step; remainder < divisor, so the shifted MSB set means "fits".
  assign w_div_sh_lo = {r_hi[WIDTH-2:0], r_lo[WIDTH-1]};
  assign w_div_ge    = r_hi[WIDTH-1] | (w_div_sh_lo >= r_op);
  assign w_div_diff  = w_div_sh_lo - r_op;
  assign w_div_rem   = w_div_ge ? w_div_diff : w_div_sh_lo;
  assign w_div_q     = {r_lo[WIDTH-2:0], w_div_ge};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_op        <= '0;
      r_hi        <= '0;
      r_lo        <= '0;
      in_ready    <= 1'b0;
      out_valid   <= 1'b0;
      out         <= '0;
      out_hi      <= '0;
      zero        <= 1'b0;
      v_flg       <= 1'b0;
      c_out       <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            in_ready <= 1'b0;
            r_cnt    <= '0;
            if (w_start_mul) begin
              r_op    <= inp_a;
              r_hi    <= '0;
              r_lo    <= inp_b;
              r_state <= S_MUL;
            end else if (w_start_div) begin
              r_op    <= inp_b;
              r_hi    <= '0;
              r_lo    <= inp_a;
              r_state <= S_DIV;
            end else begin
              out         <= w_res;
              out_hi      <= w_res_hi;
              zero        <= ~|w_res;
              v_flg       <= w_v;
              c_out       <= w_c;
              div_by_zero <= w_dbz;
              out_valid   <= 1'b1;
              r_state     <= S_DONE;
            end
          end
        end
        S_MUL: begin
          r_hi  <= w_mul_hi;
          r_lo  <= w_mul_lo;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == c_last) begin
            out         <= w_mul_lo;
            out_hi      <= w_mul_hi;
            zero        <= ~|w_mul_lo;
            v_flg       <= 1'b0;
            c_out       <= 1'b0;
            div_by_zero <= 1'b0;
            out_valid   <= 1'b1;
            r_state     <= S_DONE;
          end
        end
        S_DIV: begin
          r_hi  <= w_div_rem;
          r_lo  <= w_div_q;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == c_last) begin
            out         <= w_div_q;
            out_hi      <= w_div_rem;
            zero        <= ~|w_div_q;
            v_flg       <= 1'b0;
            c_out       <= 1'b0;
            div_by_zero <= 1'b0;
            out_valid   <= 1'b1;
            r_state     <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            r_state   <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_iter.sv
// ============================================================================
//  Module   : tb_alu_iter
//  Brief    : Directed self-checking bench for alu_iter (WIDTH=32).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_iter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  alu_ctr;
  logic [31:0] inp_a;
  logic [31:0] inp_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out;
  logic [31:0] out_hi;
  logic        zero;
  logic        v_flg;
  logic        c_out;
  logic        div_by_zero;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  alu_iter #(.WIDTH(32), .MUL_EN(1), .DIV_EN(1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .alu_ctr    (alu_ctr),
    .inp_a      (inp_a),
    .inp_b      (inp_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out        (out),
    .out_hi     (out_hi),
    .zero       (zero),
    .v_flg      (v_flg),
    .c_out      (c_out),
    .div_by_zero(div_by_zero)
  );

  // Present a request and return 1 time unit after the accepting edge.
  task automatic issue(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    int n = 0;
    alu_ctr  = c;
    inp_a    = a;
    inp_b    = b;
    in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    n_checks++;
    if (!in_ready) begin
      $display("FAIL accept_timeout: in_ready=%0b required 1", in_ready);
      in_valid = 1'b0;
      return;
    end
    n_pass++;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic take();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    alu_ctr = '0; inp_a = '0; inp_b = '0;
    #2;
    n_checks++;
    if ({out_valid, in_ready, out, out_hi, zero, v_flg, c_out, div_by_zero} !== '0)
      $display("FAIL reset_outputs: got valid=%0b rdy=%0b out=%h hi=%h required all 0", out_valid, in_ready, out, out_hi);
    else n_pass++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL reset_release: in_ready=%0b out_valid=%0b required 1/0", in_ready, out_valid);
    else n_pass++;
  endtask

  task automatic test_add_overflow();
    issue(4'b0001, 32'h7FFF_FFFF, 32'h1);
    n_checks++;
    if ({out_valid, out, out_hi, v_flg, c_out, zero} !== {1'b1, 32'h8000_0000, 32'h0, 1'b1, 1'b0, 1'b0})
      $display("FAIL add_ovf: valid=%0b out=%h hi=%h v=%0b c=%0b z=%0b required 1 80000000 0 1 0 0",
               out_valid, out, out_hi, v_flg, c_out, zero);
    else n_pass++;
    take();
  endtask

  task automatic test_sub_then_sll();
    issue(4'b0010, 32'd5, 32'd5);
    n_checks++;
    if ({out, zero, c_out, v_flg} !== {32'h0, 1'b1, 1'b1, 1'b0})
      $display("FAIL sub_zero: out=%h z=%0b c=%0b v=%0b required 0 1 1 0", out, zero, c_out, v_flg);
    else n_pass++;
    take();
    issue(4'b0011, 32'd4, 32'd1);
    n_checks++;
    if ({out, zero, c_out, v_flg} !== {32'h10, 1'b0, 1'b0, 1'b0})
      $display("FAIL sll_flags: out=%h z=%0b c=%0b v=%0b required 10 0 0 0", out, zero, c_out, v_flg);
    else n_pass++;
    take();
  endtask

  // Back-to-back single-cycle ops; each accepted right after the previous take.
  task automatic test_single_ops();
    logic [3:0]  c_tab [10] = '{4'b1000, 4'b0101, 4'b0100, 4'b0011, 4'b1011,
                                4'b1111, 4'b1110, 4'b1010, 4'b1001, 4'b0000};
    logic [31:0] a_tab [10] = '{32'hF0F0_F0F0, 32'd4, 32'd31, 32'd33, 32'hFFFF_FFFF,
                                32'hFFFF_FFFF, 32'h1234, 32'h0, 32'd5, 32'd7};
    logic [31:0] b_tab [10] = '{32'hFF00_FF00, 32'h8000_0000, 32'h8000_0000, 32'h1, 32'h1,
                                32'h1, 32'h1234, 32'h0, 32'd5, 32'd9};
    logic [31:0] e_tab [10] = '{32'h0FF0_0FF0, 32'hF800_0000, 32'h1, 32'h2, 32'h1,
                                32'h0, 32'h1, 32'hFFFF_FFFF, 32'h0, 32'h0};
    for (int i = 0; i < 10; i++) begin
      issue(c_tab[i], a_tab[i], b_tab[i]);
      n_checks++;
      if ({out_valid, out, out_hi, zero, v_flg, c_out, div_by_zero} !==
          {1'b1, e_tab[i], 32'h0, (e_tab[i] == 32'h0), 3'b000})
        $display("FAIL single_op[%0d] ctr=%b: valid=%0b out=%h hi=%h z=%0b flags=%0b%0b%0b required out=%h",
                 i, c_tab[i], out_valid, out, out_hi, zero, v_flg, c_out, div_by_zero, e_tab[i]);
      else n_pass++;
      take();
    end
  endtask

  task automatic test_mul();
    logic bad = 1'b0;
    issue(4'b1100, 32'hFFFF_FFFF, 32'h2);
    for (int i = 1; i <= 31; i++) begin
      if (out_valid !== 1'b0 || in_ready !== 1'b0) bad = 1'b1;
      @(posedge clk); #1;
    end
    n_checks++;
    if (bad || out_valid !== 1'b0 || in_ready !== 1'b0)
      $display("FAIL mul_busy: early valid or ready (valid=%0b rdy=%0b) required 0/0", out_valid, in_ready);
    else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if ({out_valid, in_ready, out, out_hi, zero, v_flg, c_out} !== {1'b1, 1'b0, 32'hFFFF_FFFE, 32'h1, 3'b000})
      $display("FAIL mul_result: valid=%0b rdy=%0b out=%h hi=%h required 1 0 FFFFFFFE 1", out_valid, in_ready, out, out_hi);
    else n_pass++;
    take();
  endtask

  task automatic test_div();
    logic [31:0] a_tab [2] = '{32'd100, 32'd5};
    logic [31:0] q_tab [2] = '{32'd14, 32'd0};
    logic [31:0] r_tab [2] = '{32'd2, 32'd5};
    for (int k = 0; k < 2; k++) begin
      issue(4'b1101, a_tab[k], 32'd7);
      repeat (31) @(posedge clk);
      #1;
      n_checks++;
      if (out_valid !== 1'b0)
        $display("FAIL div_early[%0d]: out_valid=%0b required 0", k, out_valid);
      else n_pass++;
      @(posedge clk); #1;
      n_checks++;
      if ({out_valid, out, out_hi, zero, div_by_zero} !== {1'b1, q_tab[k], r_tab[k], (q_tab[k] == 32'h0), 1'b0})
        $display("FAIL div_result[%0d]: valid=%0b q=%h r=%h z=%0b dbz=%0b required q=%h r=%h",
                 k, out_valid, out, out_hi, zero, div_by_zero, q_tab[k], r_tab[k]);
      else n_pass++;
      take();
    end
    issue(4'b1101, 32'd9, 32'd0);
    n_checks++;
    if ({out_valid, out, out_hi, div_by_zero, zero} !== {1'b1, 32'hFFFF_FFFF, 32'd9, 1'b1, 1'b0})
      $display("FAIL div_by_zero: valid=%0b out=%h hi=%h dbz=%0b required 1 FFFFFFFF 9 1", out_valid, out, out_hi, div_by_zero);
    else n_pass++;
    take();
  endtask

  task automatic test_backpressure();
    logic bad = 1'b0;
    issue(4'b0001, 32'd10, 32'd20);
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      alu_ctr = 4'b0111; inp_a = 32'h100 << i; inp_b = 32'h5 + i;
      @(posedge clk); #1;
      if (out !== 32'd30 || out_valid !== 1'b1 || in_ready !== 1'b0) bad = 1'b1;
    end
    n_checks++;
    if (bad)
      $display("FAIL backpressure_hold: out=%h valid=%0b rdy=%0b required 0000001e 1 0", out, out_valid, in_ready);
    else n_pass++;
    in_valid = 1'b0;
    take();
    @(posedge clk); #1;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL backpressure_noaccept: valid=%0b rdy=%0b required 0 1", out_valid, in_ready);
    else n_pass++;
  endtask

  task automatic test_reset_mid_mul();
    issue(4'b1100, 32'hFFFF_FFFF, 32'h2);
    repeat (9) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({out_valid, in_ready, out, out_hi, zero, v_flg, c_out, div_by_zero} !== '0)
      $display("FAIL reset_mid_mul: valid=%0b rdy=%0b out=%h hi=%h required all 0", out_valid, in_ready, out, out_hi);
    else n_pass++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL reset_mid_mul_release: rdy=%0b valid=%0b required 1 0", in_ready, out_valid);
    else n_pass++;
    issue(4'b0001, 32'd2, 32'd3);
    n_checks++;
    if ({out_valid, out, out_hi, v_flg, c_out, zero} !== {1'b1, 32'd5, 32'd0, 3'b000})
      $display("FAIL add_after_reset: valid=%0b out=%h hi=%h required 1 5 0", out_valid, out, out_hi);
    else n_pass++;
    take();
  endtask

  initial begin
    test_reset();
    test_add_overflow();
    test_sub_then_sll();
    test_single_ops();
    test_mul();
    test_div();
    test_backpressure();
    test_reset_mid_mul();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
